oddeven_stride_counter: RTL and testbench



---
 rtl/oddeven_pkg.sv | 22 ++
 rtl/oddeven_next_val.sv | 73 +++++++
 rtl/oddeven_stride_counter.sv | 86 ++++++++
 tb/tb_oddeven_stride_counter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/oddeven_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oddeven_pkg
//  Description : Shared definitions for the odd/even stride counter:
//                mode encodings, direction constants and the mode type.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package oddeven_pkg;

   // Counting modes as presented on the 2-bit mode input
   typedef enum logic [1:0] {
      MODE_EVEN = 2'b00,
      MODE_ODD  = 2'b01,
      MODE_ALL  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/oddeven_next_val.sv
`default_nettype none
// ============================================================================
//  Module      : oddeven_next_val
//  Description : Combinational next-value generator for the stride counter.
//                Picks a step of 1 or 2 from mode and current parity, applies
//                it in the requested direction and reports boundary crossing.
//  Config      : ODDEVEN_STRIDE_SAT_EN defined -> clamp at the mode limits
//                and raise limit instead of wrapping.
//  Ports       : count      - current counter value
//                mode       - counting mode (EVEN/ODD/ALL/RSVD)
//                dir        - 1 up, 0 down
//                next_count - value after one enabled step
//                crossed    - modular wrap happened (wrapping build only)
//                limit      - step was clamped at a limit (saturating build)
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module oddeven_next_val
   import oddeven_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] count,
   input  mode_t            mode,
   input  logic             dir,
   output logic [WIDTH-1:0] next_count,
   output logic             crossed,
   output logic             limit
);

   logic [WIDTH-1:0] w_step;
   // One extra bit to catch carry (up) or borrow (down)
   logic [WIDTH:0]   w_sum;
`ifdef ODDEVEN_STRIDE_SAT_EN
   logic [WIDTH-1:0] w_hi;
   logic [WIDTH-1:0] w_lo;
`endif

   always_comb begin
      // A count whose parity disagrees with the mode moves by 1 to realign
      case (mode)
         MODE_ALL:  w_step = WIDTH'(1);
         MODE_EVEN: w_step = count[0] ? WIDTH'(1) : WIDTH'(2);
         MODE_ODD:  w_step = count[0] ? WIDTH'(2) : WIDTH'(1);
         default:   w_step = '0;
      endcase

      if (dir == DIR_UP)
         w_sum = {1'b0, count} + {1'b0, w_step};
      else
         w_sum = {1'b0, count} - {1'b0, w_step};

`ifdef ODDEVEN_STRIDE_SAT_EN
      w_hi = (mode == MODE_EVEN) ? {{(WIDTH-1){1'b1}}, 1'b0} : {WIDTH{1'b1}};
      w_lo = (mode == MODE_ODD)  ? WIDTH'(1) : '0;
      crossed = 1'b0;
      // Any crossing lands on the limit of the travel direction; this also
      // pulls an out-of-range realign (e.g. EVEN up from all-ones) inward.
      if (w_sum[WIDTH]) begin
         next_count = (dir == DIR_UP) ? w_hi : w_lo;
         limit      = 1'b1;
      end else begin
         next_count = w_sum[WIDTH-1:0];
         limit      = 1'b0;
      end
`else
      next_count = w_sum[WIDTH-1:0];
      crossed    = w_sum[WIDTH];
      limit      = 1'b0;
`endif
   end

endmodule
`default_nettype wire

// File: rtl/oddeven_stride_counter.sv
`default_nettype none
// ============================================================================
//  Module      : oddeven_stride_counter
//  Description : Parametrised odd/even/all-integer up/down counter with
//                clock enable, parity-forcing parallel load and a registered
//                wrap (or saturation-limit) indication.
//  Config      : ODDEVEN_STRIDE_SAT_EN defined -> count saturates at the mode
//                limits and wrap becomes a level while a step is blocked.
//  Ports       : clk      - rising-edge clock
//                reset_n  - synchronous active-low reset
//                en       - count enable
//                mode     - 00 EVEN, 01 ODD, 10 ALL, 11 hold
//                dir      - 1 up, 0 down
//                load     - parallel load strobe (beats en)
//                load_val - load value, parity forced by mode
//                count    - registered count
//                wrap     - registered wrap pulse / limit flag
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module oddeven_stride_counter
   import oddeven_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   mode_t            w_mode;
   logic [WIDTH-1:0] w_next;
   logic             w_crossed;
   logic             w_limit;
   logic [WIDTH-1:0] w_load_val;

   assign w_mode = mode_t'(mode);

   oddeven_next_val #(
      .WIDTH (WIDTH)
   ) u_next_val (
      .count      (r_count),
      .mode       (w_mode),
      .dir        (dir),
      .next_count (w_next),
      .crossed    (w_crossed),
      .limit      (w_limit)
   );

   // Loaded value takes the parity of the current mode
   always_comb begin
      case (w_mode)
         MODE_ODD:  w_load_val = load_val | WIDTH'(1);
         MODE_EVEN: w_load_val = load_val & ~WIDTH'(1);
         default:   w_load_val = load_val;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_count <= (w_mode == MODE_ODD) ? WIDTH'(1) : '0;
         r_wrap  <= 1'b0;
      end else if (load) begin
         r_count <= w_load_val;
         r_wrap  <= 1'b0;
      end else if (en && (w_mode != MODE_RSVD)) begin
         r_count <= w_next;
         // Only one of these can be set, depending on the build
         r_wrap  <= w_crossed | w_limit;
      end else begin
         r_wrap  <= 1'b0;
      end
   end

   assign count = r_count;
   assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_oddeven_stride_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oddeven_stride_counter
//  Description : Directed self-checking bench for oddeven_stride_counter in
//                its default (modular wrap) build. One 16-bit and one 4-bit
//                instance share the clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oddeven_stride_counter;

   logic        clk = 1'b0;

   // 16-bit instance
   logic        a_reset_n, a_en, a_dir, a_load, a_wrap;
   logic [1:0]  a_mode;
   logic [15:0] a_load_val, a_count;

   // 4-bit instance
   logic        b_reset_n, b_en, b_dir, b_load, b_wrap;
   logic [1:0]  b_mode;
   logic [3:0]  b_load_val, b_count;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   oddeven_stride_counter #(.WIDTH(16)) u_dut16 (
      .clk      (clk),
      .reset_n  (a_reset_n),
      .en       (a_en),
      .mode     (a_mode),
      .dir      (a_dir),
      .load     (a_load),
      .load_val (a_load_val),
      .count    (a_count),
      .wrap     (a_wrap)
   );

   oddeven_stride_counter #(.WIDTH(4)) u_dut4 (
      .clk      (clk),
      .reset_n  (b_reset_n),
      .en       (b_en),
      .mode     (b_mode),
      .dir      (b_dir),
      .load     (b_load),
      .load_val (b_load_val),
      .count    (b_count),
      .wrap     (b_wrap)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_a(input string tag, input logic [15:0] exp_count, input logic exp_wrap);
      tick();
      check({tag, ".count"}, 32'(a_count), 32'(exp_count));
      check({tag, ".wrap"},  32'(a_wrap),  32'(exp_wrap));
   endtask

   task automatic tick_b(input string tag, input logic [3:0] exp_count, input logic exp_wrap);
      tick();
      check({tag, ".count"}, 32'(b_count), 32'(exp_count));
      check({tag, ".wrap"},  32'(b_wrap),  32'(exp_wrap));
   endtask

   initial begin
      a_reset_n = 1'b0; a_en = 1'b0; a_dir = 1'b1; a_load = 1'b0;
      a_mode = 2'b01; a_load_val = 16'h0000;
      b_reset_n = 1'b0; b_en = 1'b0; b_dir = 1'b1; b_load = 1'b0;
      b_mode = 2'b10; b_load_val = 4'h0;

      // Reset: ODD gives 1, ALL gives 0
      tick_a("rst_odd", 16'h0001, 1'b0);
      check("rst_all.count", 32'(b_count), 32'h0);
      a_reset_n = 1'b1; b_reset_n = 1'b1;

      // ODD up from reset value
      a_en = 1'b1;
      tick_a("odd_up1", 16'h0003, 1'b0);
      tick_a("odd_up2", 16'h0005, 1'b0);
      tick_a("odd_up3", 16'h0007, 1'b0);

      // en low holds and clears wrap
      a_en = 1'b0;
      tick_a("hold", 16'h0007, 1'b0);

      // ODD load near top, wrap to 1
      a_load = 1'b1; a_load_val = 16'hFFFB;
      tick_a("ld_fffb", 16'hFFFB, 1'b0);
      a_load = 1'b0; a_en = 1'b1;
      tick_a("odd_wr1", 16'hFFFD, 1'b0);
      tick_a("odd_wr2", 16'hFFFF, 1'b0);
      tick_a("odd_wr3", 16'h0001, 1'b1);
      tick_a("odd_wr4", 16'h0003, 1'b0);

      // EVEN at 6, then ODD down realigns to 5 and wraps below 1
      a_load = 1'b1; a_mode = 2'b00; a_load_val = 16'h0006;
      tick_a("ld_6", 16'h0006, 1'b0);
      a_load = 1'b0; a_mode = 2'b01; a_dir = 1'b0;
      tick_a("realign_dn", 16'h0005, 1'b0);
      tick_a("odd_dn1", 16'h0003, 1'b0);
      tick_a("odd_dn2", 16'h0001, 1'b0);
      tick_a("odd_dn_wr", 16'hFFFF, 1'b1);
      tick_a("odd_dn3", 16'hFFFD, 1'b0);

      // Parity-forced load, then load beats en
      a_en = 1'b0; a_load = 1'b1; a_load_val = 16'h0010;
      tick_a("ld_force_odd", 16'h0011, 1'b0);
      a_en = 1'b1; a_load_val = 16'h0021; a_mode = 2'b00;
      tick_a("ld_force_even", 16'h0020, 1'b0);
      a_load = 1'b0; a_mode = 2'b11;
      for (int i = 0; i < 5; i++)
         tick_a("rsvd_hold", 16'h0020, 1'b0);

      // Reset mid-sequence overrides load and en, EVEN resets to 0
      a_mode = 2'b00; a_reset_n = 1'b0; a_load = 1'b1; a_load_val = 16'h1234;
      tick_a("rst_even", 16'h0000, 1'b0);
      a_reset_n = 1'b1; a_load = 1'b0; a_dir = 1'b1;
      tick_a("even_up", 16'h0002, 1'b0);

      // EVEN up realign from odd: 5 -> 6 (no wrap), 0xFFFF -> 0 (wrap)
      a_load = 1'b1; a_mode = 2'b10; a_load_val = 16'h0005;
      tick_a("ld_all_5", 16'h0005, 1'b0);
      a_load = 1'b0; a_mode = 2'b00;
      tick_a("realign_up", 16'h0006, 1'b0);
      a_load = 1'b1; a_mode = 2'b10; a_load_val = 16'hFFFF;
      tick_a("ld_all_ffff", 16'hFFFF, 1'b0);
      a_load = 1'b0; a_mode = 2'b00;
      tick_a("realign_wr", 16'h0000, 1'b1);
      a_dir = 1'b0;
      tick_a("even_dn_wr", 16'hFFFE, 1'b1);
      a_en = 1'b0;

      // 4-bit ALL up through wrap, then EVEN down wrap
      b_load = 1'b1; b_load_val = 4'hE;
      tick_b("b_ld_e", 4'hE, 1'b0);
      b_load = 1'b0; b_en = 1'b1;
      tick_b("b_all1", 4'hF, 1'b0);
      tick_b("b_all_wr", 4'h0, 1'b1);
      tick_b("b_all2", 4'h1, 1'b0);
      b_load = 1'b1; b_mode = 2'b00; b_load_val = 4'h1;
      tick_b("b_ld_even", 4'h0, 1'b0);
      b_load = 1'b0; b_dir = 1'b0;
      tick_b("b_even_dn_wr", 4'hE, 1'b1);
      tick_b("b_even_dn", 4'hC, 1'b0);
      b_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
